// File: rtl/nonce_dispatcher.sv
// Nonce search sequencer for a single miner core.
// Walks nonces start..end (inclusive, wrapping mod 2^32), launches one hash per
// nonce, compares each digest against the latched target and reports the first
// winning nonce. A watchdog bounds the time spent waiting on the core.
module nonce_dispatcher #(
   parameter int TIMEOUT = 1023
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [0:607] header,
   input  logic [0:255] target,
   input  logic [31:0]  start_nonce,
   input  logic [31:0]  end_nonce,
   output logic         hash_enable,
   output logic [0:639] message,
   input  logic         finished,
   input  logic [0:255] hash,
   output logic         busy,
   output logic         found,
   output logic [31:0]  found_nonce,
   output logic         done,
   output logic         error
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LAUNCH = 3'd1;
   localparam logic [2:0] WAIT   = 3'd2;
   localparam logic [2:0] CHECK  = 3'd3;
   localparam logic [2:0] DRAIN  = 3'd4;

   // Watchdog is wide enough to hold TIMEOUT itself; it exits on TIMEOUT-1.
   localparam int             WDW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

   // Everything captured from the requester when a search is accepted.
   typedef struct packed {
      logic [0:607] header;
      logic [0:255] target;
      logic [31:0]  end_nonce;
   } job_t;

   logic [2:0]     state, state_d;
   job_t           job;
   logic [31:0]    nonce;
   logic [WDW-1:0] wd;
   logic [0:255]   hash_q;

   // Per-cycle decisions produced by the next-state logic.
   logic accept;     // start taken in IDLE
   logic capture;    // digest registered for CHECK
   logic advance;    // step to the next nonce
   logic end_plain;  // search over without a winner (exhausted / aborted / drained)
   logic end_found;  // search over with a winner
   logic timeout;    // watchdog expired
   logic wd_expire;
   logic win;
   logic last;

   assign wd_expire = (wd == WD_LAST);
   // Both operands are [0:255], so index 0 is the MSB of the unsigned compare.
   assign win       = (hash_q < job.target);
   assign last      = (nonce == job.end_nonce);

   assign hash_enable = (state == LAUNCH);
   assign busy        = (state != IDLE);
   assign message     = {job.header, nonce};

   // Next-state and control strobes; abort outranks a win in CHECK.
   always_comb begin
      state_d   = state;
      accept    = 1'b0;
      capture   = 1'b0;
      advance   = 1'b0;
      end_plain = 1'b0;
      end_found = 1'b0;
      timeout   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            if (abort) begin
               end_plain = 1'b1;
               state_d   = IDLE;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (finished && abort) begin
               // Result and abort coincide: nothing left in flight, finish now.
               end_plain = 1'b1;
               state_d   = IDLE;
            end else if (finished) begin
               capture = 1'b1;
               state_d = CHECK;
            end else if (wd_expire) begin
               timeout = 1'b1;
               state_d = IDLE;
            end else if (abort) begin
               // Core still owes a result; wait it out so it cannot leak into
               // the next search.
               state_d = DRAIN;
            end
         end
         CHECK: begin
            if (abort) begin
               end_plain = 1'b1;
               state_d   = IDLE;
            end else if (win) begin
               end_found = 1'b1;
               state_d   = IDLE;
            end else if (last) begin
               end_plain = 1'b1;
               state_d   = IDLE;
            end else begin
               advance = 1'b1;
               state_d = LAUNCH;
            end
         end
         DRAIN: begin
            if (finished) begin
               end_plain = 1'b1;
               state_d   = IDLE;
            end else if (wd_expire) begin
               timeout = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // Job latch; only written when a start is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         job <= '0;
      else if (accept) job <= '{header: header, target: target, end_nonce: end_nonce};
   end

   // Current nonce; natural 32-bit overflow gives the FFFFFFFF->0 wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          nonce <= '0;
      else if (accept)  nonce <= start_nonce;
      else if (advance) nonce <= nonce + 32'd1;
   end

   // Watchdog: zeroed on each launch, counts every WAIT/DRAIN cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                 wd <= '0;
      else if (state == LAUNCH)                wd <= '0;
      else if (state == WAIT || state == DRAIN) wd <= wd + 1'b1;
   end

   // Digest register feeding the CHECK compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          hash_q <= '0;
      else if (capture) hash_q <= hash;
   end

   // Completion pulses, one cycle each.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done  <= 1'b0;
         found <= 1'b0;
      end else begin
         done  <= end_plain | end_found | timeout;
         found <= end_found;
      end
   end

   // Winning nonce; held until the next accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            found_nonce <= '0;
      else if (accept)    found_nonce <= '0;
      else if (end_found) found_nonce <= nonce;
   end

   // Sticky timeout flag, cleared by the next accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          error <= 1'b0;
      else if (accept)  error <= 1'b0;
      else if (timeout) error <= 1'b1;
   end

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Scoreboard bench for nonce_dispatcher: tests queue expected launch/done
// events, a monitor pops and compares them, a behavioural core answers launches.
module tb_nonce_dispatcher;

   localparam int TO = 15;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [0:607] header = '0;
   logic [0:255] target = '0;
   logic [31:0]  start_nonce = '0;
   logic [31:0]  end_nonce = '0;
   logic         hash_enable;
   logic [0:639] message;
   logic         finished = 1'b0;
   logic [0:255] hash = '0;
   logic         busy, found, done, error;
   logic [31:0]  found_nonce;

   always #5 clk = ~clk;

   nonce_dispatcher #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .header(header), .target(target), .start_nonce(start_nonce), .end_nonce(end_nonce),
      .hash_enable(hash_enable), .message(message), .finished(finished), .hash(hash),
      .busy(busy), .found(found), .found_nonce(found_nonce), .done(done), .error(error)
   );

   typedef struct {
      bit          is_done;
      logic [31:0] nonce;
      bit          fnd;
      bit          err;
   } ev_t;

   ev_t          expq[$];
   logic [255:0] htab [bit [31:0]];
   logic [607:0] cur_hdr;
   logic [255:0] tgt;

   int nchk = 0;
   int nerr = 0;
   int cyc = 0;
   int core_lat = 1;
   bit core_mute = 0;
   bit core_busy = 0;
   bit fin_pend = 0;
   int fin_cyc = 0;
   int launch_cyc = 0;
   int done_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      nchk++;
      nerr++;
      $display("FAIL %s: event not expected or never arrived", nm);
   endtask

   task automatic exp_launch(input logic [31:0] n);
      ev_t e;
      e.is_done = 0; e.nonce = n; e.fnd = 0; e.err = 0;
      expq.push_back(e);
   endtask

   task automatic exp_done(input bit f, input logic [31:0] n, input bit er);
      ev_t e;
      e.is_done = 1; e.nonce = n; e.fnd = f; e.err = er;
      expq.push_back(e);
   endtask

   // Returns at the negedge of the LAUNCH cycle.
   task automatic issue(input logic [31:0] sn, input logic [31:0] en);
      fin_pend = 0;
      @(negedge clk);
      header = cur_hdr; target = tgt;
      start_nonce = sn; end_nonce = en; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int budget);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy && !core_busy && expq.size() == 0) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         fail_now(nm);
         expq.delete();
      end
   endtask

   // Behavioural miner core: answers each launch core_lat cycles later.
   initial begin : core
      logic [31:0] cn;
      forever begin
         @(negedge clk);
         if (!rst && hash_enable && !core_mute) begin
            core_busy = 1;
            cn = message[608:639];
            repeat (core_lat) @(negedge clk);
            chk("msg_stable", message[608:639], cn);
            hash = htab.exists(cn) ? htab[cn] : '1;
            finished = 1'b1;
            fin_cyc = cyc;
            fin_pend = 1;
            @(negedge clk);
            finished = 1'b0;
            core_busy = 0;
         end
      end
   end

   // Monitor: every launch/done pulse must match the head of the queue.
   always @(negedge clk) begin : mon
      ev_t e;
      if (!rst) begin
         if (hash_enable) begin
            launch_cyc = cyc;
            if (expq.size() == 0) fail_now("unexpected_launch");
            else begin
               e = expq.pop_front();
               chk("launch_kind", 64'(e.is_done), 0);
               chk("launch_nonce", message[608:639], e.nonce);
               chk("launch_hdr", 64'(message[0:607] == cur_hdr), 1);
               if (fin_pend) chk("launch_gap", 64'(cyc - fin_cyc), 2);
            end
            fin_pend = 0;
         end
         if (done) begin
            done_cyc = cyc;
            if (expq.size() == 0) fail_now("unexpected_done");
            else begin
               e = expq.pop_front();
               chk("done_kind", 64'(e.is_done), 1);
               chk("done_found", 64'(found), 64'(e.fnd));
               if (e.fnd) chk("found_nonce", found_nonce, e.nonce);
               chk("done_error", 64'(error), 64'(e.err));
            end
            fin_pend = 0;
         end
         if (found && !done) fail_now("found_without_done");
      end
   end

   initial begin : guard
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin : stim
      cur_hdr = {19{32'hDEADBEEF}};
      tgt = 256'h00000000_FFFF0000_00000000_00000000_00000000_00000000_00000000_00000000;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_hen", 64'(hash_enable), 0);
      chk("rst_msg", 64'(message == '0), 1);
      chk("rst_done", 64'({found, done, error}), 0);
      chk("rst_fnonce", found_nonce, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", 64'(busy), 0);

      // Single nonce, winning hash
      htab.delete(); htab[32'h42a14695] = 256'h1; core_lat = 1;
      exp_launch(32'h42a14695); exp_done(1, 32'h42a14695, 0);
      issue(32'h42a14695, 32'h42a14695);
      wait_idle("t_single", 100);

      // Exhaust 0..3, plus a start while busy that must be ignored
      htab.delete(); core_lat = 3;
      for (int i = 0; i < 4; i++) exp_launch(32'(i));
      exp_done(0, 0, 0);
      issue(32'd0, 32'd3);
      repeat (2) @(negedge clk);
      start_nonce = 32'd500; end_nonce = 32'd500; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle("t_exhaust", 200);

      // Wrap across 2^32
      cur_hdr = {19{32'h0BADF00D}};
      htab.delete(); core_lat = 2;
      exp_launch(32'hFFFFFFFE); exp_launch(32'hFFFFFFFF);
      exp_launch(32'h00000000); exp_launch(32'h00000001);
      exp_done(0, 0, 0);
      issue(32'hFFFFFFFE, 32'h00000001);
      wait_idle("t_wrap", 200);

      // hash == target is not a win; target-1 is
      htab.delete(); htab[10] = tgt; htab[11] = tgt - 256'd1; core_lat = 1;
      exp_launch(10); exp_launch(11); exp_done(1, 11, 0);
      issue(32'd10, 32'd12);
      wait_idle("t_equal", 200);

      // Abort in WAIT, core answers later: drain then done
      htab.delete(); core_lat = 10;
      exp_launch(100); exp_done(0, 0, 0);
      issue(32'd100, 32'd200);
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("drain_busy", 64'(busy), 1);
      wait_idle("t_drain", 100);
      chk("drain_done_after_fin", 64'(done_cyc - fin_cyc), 1);

      // Abort and finished together in WAIT: winning result discarded
      htab.delete(); htab[300] = 256'h0; core_lat = 3;
      exp_launch(300); exp_done(0, 0, 0);
      issue(32'd300, 32'd310);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("same_cycle_idle", 64'(busy), 0);
      wait_idle("t_abort_fin", 100);

      // Abort in LAUNCH; late finished in IDLE must be ignored
      htab.delete(); htab[7] = 256'h0; core_lat = 2;
      exp_launch(7); exp_done(0, 0, 0);
      fin_pend = 0;
      @(negedge clk); start = 1'b1; start_nonce = 32'd7; end_nonce = 32'd9;
      @(negedge clk); start = 1'b0; abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      wait_idle("t_abort_launch", 100);
      chk("abort_launch_found", 64'(found_nonce), 0);

      // Watchdog timeout
      htab.delete(); core_mute = 1;
      exp_launch(5); exp_done(0, 0, 1);
      issue(32'd5, 32'd9);
      wait_idle("t_timeout", 100);
      chk("timeout_latency", 64'(done_cyc - launch_cyc), 64'(TO + 1));
      repeat (3) @(negedge clk);
      chk("error_sticky", 64'(error), 1);

      // Next start clears error
      core_mute = 0; htab.delete(); htab[20] = 256'h0; core_lat = 4;
      exp_launch(20); exp_done(1, 20, 0);
      issue(32'd20, 32'd20);
      wait_idle("t_clear_err", 100);

      // Asynchronous reset mid-WAIT: no done, everything zero at once
      core_mute = 1;
      exp_launch(77);
      issue(32'd77, 32'd80);
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", 64'(busy), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 64'(busy), 0);
      chk("arst_msg", 64'(message == '0), 1);
      chk("arst_outs", 64'({hash_enable, found, done, error}), 0);
      chk("arst_fnonce", found_nonce, 0);
      chk("arst_queue", 64'(expq.size()), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("post_arst_idle", 64'({busy, done}), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
